// File: rtl/xsim_bus_mem_slave_pkg.sv
// Shared encodings for the simulation-bus memory slave: bus rw values, reset polarity and slave FSM states.
// The no-master ID is all-ones at whatever ID width the top is built with, so the top derives it locally.
package xsim_bus_mem_slave_pkg;

    localparam logic XSimBusWrite = 1'b1;
    localparam logic XSimBusRead  = 1'b0;
    localparam logic RstEnable    = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } SlaveState;

endpackage

// File: rtl/xsim_bus_mem_slave_ram.sv
// Byte-wide synchronous RAM for the bus memory slave: one write port and one registered read port.
// The read register only moves on a read, so the last read byte stays visible between reads.
module xsim_slave_ram
    import xsim_bus_mem_slave_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem [0:(2**ADDR_W)-1];
    logic [7:0] rdata_q;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/xsim_bus_mem_slave.sv
// Byte-wide memory slave behind the simulation bus arbiter: select/edge detection, one pending slot,
// IDLE/ACCESS/RESP FSM and response pulses. Define XSIM_SLAVE_WPROT_EN to reject writes below WP_LIMIT.
module xsim_bus_mem_slave
    import xsim_bus_mem_slave_pkg::*;
#(
    parameter int DEV_ID   = 1,
    parameter int DEV_ID_W = 5,
    parameter int ADDR_W   = 10,
    parameter int WP_LIMIT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold_flag_in,
    input  logic [DEV_ID_W-1:0] device_id_in,
    input  logic [ADDR_W-1:0]   device_addr_in,
    input  logic [DEV_ID_W-1:0] master_id_in,
    input  logic                master_rw_in,
    input  logic [7:0]          wdata_in,
    output logic [7:0]          rdata_out,
    output logic                rvalid_out,
    output logic                ack_out,
    output logic [DEV_ID_W-1:0] resp_master_id_out,
    output logic                err_out,
    output logic                busy_out,
    output logic                overflow_out
);

    localparam int TW = DEV_ID_W + ADDR_W + 1 + 8;
    localparam logic [DEV_ID_W-1:0] DevId    = DEV_ID[DEV_ID_W-1:0];
    localparam logic [DEV_ID_W-1:0] NoMaster = '1;

    SlaveState      state_q, state_d;
    logic           sel_q;
    logic [TW-1:0]  tuple_q;
    logic [TW-1:0]  cur_q, cur_d;
    logic [TW-1:0]  pend_q, pend_d;
    logic           pendValid_q, pendValid_d;
    logic           overflow_q, overflow_d;

    logic           selNow, newReq, consume, wpHit;
    logic [TW-1:0]  tupleNow;
    logic [DEV_ID_W-1:0] curMaster;
    logic [ADDR_W-1:0]   curAddr;
    logic                curRw;
    logic [7:0]          curWdata;
    logic                ramWe, ramRe;

    assign selNow   = hold_flag_in & (device_id_in == DevId);
    assign tupleNow = {master_id_in, device_addr_in, master_rw_in, wdata_in};
    // A held bus with an unchanged tuple is a single transaction.
    assign newReq   = selNow & (master_id_in != NoMaster) & (!sel_q | (tupleNow != tuple_q));

    assign {curMaster, curAddr, curRw, curWdata} = cur_q;

`ifdef XSIM_SLAVE_WPROT_EN
    localparam logic [ADDR_W:0] WpLimit = (ADDR_W+1)'(WP_LIMIT);
    assign wpHit = (curRw == XSimBusWrite) && ({1'b0, curAddr} < WpLimit);
`else
    logic unusedWpLimit;
    assign unusedWpLimit = ^WP_LIMIT;
    assign wpHit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            tuple_q     <= '0;
            cur_q       <= '0;
            pend_q      <= '0;
            pendValid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= selNow;
            tuple_q     <= tupleNow;
            cur_q       <= cur_d;
            pend_q      <= pend_d;
            pendValid_q <= pendValid_d;
            overflow_q  <= overflow_d;
        end
    end

    // The slot is freed before a same-edge request is considered, so that request is stored.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        pend_d      = pend_q;
        pendValid_d = pendValid_q;
        overflow_d  = 1'b0;
        consume     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pendValid_q) begin
                    cur_d   = pend_q;
                    consume = 1'b1;
                    state_d = ACCESS;
                end else if (newReq) begin
                    cur_d   = tupleNow;
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                if (pendValid_q) begin
                    cur_d   = pend_q;
                    consume = 1'b1;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (consume) begin
            pendValid_d = 1'b0;
        end
        if (newReq && !(state_q == IDLE && !pendValid_q)) begin
            if (!pendValid_d) begin
                pend_d      = tupleNow;
                pendValid_d = 1'b1;
            end else begin
                overflow_d  = 1'b1;
            end
        end
    end

    always_comb begin
        ramWe              = (state_q == ACCESS) && (curRw == XSimBusWrite) && !wpHit;
        ramRe              = (state_q == ACCESS) && (curRw == XSimBusRead);
        ack_out            = (state_q == RESP);
        rvalid_out         = (state_q == RESP) && (curRw == XSimBusRead);
        err_out            = (state_q == RESP) && wpHit;
        resp_master_id_out = (state_q == RESP) ? curMaster : NoMaster;
        busy_out           = (state_q != IDLE) || pendValid_q;
        overflow_out       = overflow_q;
    end

    xsim_slave_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ramWe),
        .re_i    (ramRe),
        .addr_i  (curAddr),
        .wdata_i (curWdata),
        .rdata_o (rdata_out)
    );

endmodule

// File: tb/tb_xsim_bus_mem_slave.sv
// Directed self-checking bench for xsim_bus_mem_slave (default parameters, DEV_ID = 1).
// Write-protect vectors are built only when XSIM_SLAVE_WPROT_EN is defined, matching the RTL build.
module tb_xsim_bus_mem_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       holdFlag = 1'b0;
    logic [4:0] deviceId = '0;
    logic [9:0] deviceAddr = '0;
    logic [4:0] masterId = '0;
    logic       masterRw = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       rvalid, ack, err, busy, overflow;
    logic [4:0] respMaster;

    int vecCount = 0;
    int missCount = 0;
    int ackTotal = 0;
    int ovfTotal = 0;
    logic [4:0] ackLog [$];

    xsim_bus_mem_slave dut (
        .clk                (clk),
        .rst                (rst),
        .hold_flag_in       (holdFlag),
        .device_id_in       (deviceId),
        .device_addr_in     (deviceAddr),
        .master_id_in       (masterId),
        .master_rw_in       (masterRw),
        .wdata_in           (wdata),
        .rdata_out          (rdata),
        .rvalid_out         (rvalid),
        .ack_out            (ack),
        .resp_master_id_out (respMaster),
        .err_out            (err),
        .busy_out           (busy),
        .overflow_out       (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack) begin
            ackTotal++;
            ackLog.push_back(respMaster);
        end
        if (overflow) begin
            ovfTotal++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic hold, input logic [4:0] dev, input logic [9:0] addr,
                                 input logic [4:0] master, input logic rw, input logic [7:0] data);
        holdFlag   = hold;
        deviceId   = dev;
        deviceAddr = addr;
        masterId   = master;
        masterRw   = rw;
        wdata      = data;
    endtask

    // Acceptance edge is the first tick; the ack is visible after the second.
    task automatic doWrite(input string tag, input logic [9:0] addr, input logic [4:0] master,
                           input logic [7:0] data, input logic expErr);
        applyStimulus(1'b1, 5'd1, addr, master, 1'b1, data);
        tick();
        checkOutput({tag, "_ack_early"}, ack, 0);
        tick();
        checkOutput({tag, "_ack"}, ack, 1);
        checkOutput({tag, "_err"}, err, expErr);
        checkOutput({tag, "_rvalid"}, rvalid, 0);
        checkOutput({tag, "_master"}, respMaster, master);
        holdFlag = 1'b0;
        tick();
    endtask

    task automatic doRead(input string tag, input logic [9:0] addr, input logic [4:0] master,
                          input logic chkData, input logic [7:0] expData, output logic [7:0] got);
        applyStimulus(1'b1, 5'd1, addr, master, 1'b0, 8'h00);
        tick();
        checkOutput({tag, "_ack_early"}, ack, 0);
        tick();
        checkOutput({tag, "_ack"}, ack, 1);
        checkOutput({tag, "_rvalid"}, rvalid, 1);
        checkOutput({tag, "_master"}, respMaster, master);
        got = rdata;
        if (chkData) begin
            checkOutput({tag, "_rdata"}, rdata, expData);
        end
        holdFlag = 1'b0;
        tick();
        checkOutput({tag, "_ack_done"}, ack, 0);
        if (chkData) begin
            checkOutput({tag, "_rdata_hold"}, rdata, expData);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int ovfBase;
        logic [7:0] got;
        logic [7:0] oldVal;

        #12;
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_master", respMaster, 5'h1F);
        rst = 1'b1;
        tick();
        tick();

        // A write held for four cycles must be one transaction.
        base = ackTotal;
        applyStimulus(1'b1, 5'd1, 10'h020, 5'd3, 1'b1, 8'hA5);
        tick();
        checkOutput("wr1_busy", busy, 1);
        checkOutput("wr1_ack_early", ack, 0);
        tick();
        checkOutput("wr1_ack", ack, 1);
        checkOutput("wr1_err", err, 0);
        checkOutput("wr1_master", respMaster, 5'd3);
        tick();
        checkOutput("wr1_ack_once", ack, 0);
        tick();
        holdFlag = 1'b0;
        repeat (4) tick();
        checkOutput("wr1_ack_count", ackTotal - base, 1);
        checkOutput("wr1_idle", busy, 0);

        doRead("rd1", 10'h020, 5'd2, 1'b1, 8'hA5, got);

        // The slot is freed on the RESP edge, so the third request of a burst is stored and the fourth overflows.
        doWrite("pre33", 10'h033, 5'd1, 8'h99, 1'b0);
        base = ackTotal;
        ovfBase = ovfTotal;
        applyStimulus(1'b1, 5'd1, 10'h030, 5'd1, 1'b1, 8'h11);
        tick();
        applyStimulus(1'b1, 5'd1, 10'h031, 5'd2, 1'b1, 8'h22);
        tick();
        applyStimulus(1'b1, 5'd1, 10'h032, 5'd4, 1'b1, 8'h33);
        tick();
        applyStimulus(1'b1, 5'd1, 10'h033, 5'd5, 1'b1, 8'hEE);
        tick();
        checkOutput("burst_ovf_pulse", overflow, 1);
        holdFlag = 1'b0;
        tick();
        checkOutput("burst_ovf_clear", overflow, 0);
        repeat (6) tick();
        checkOutput("burst_ack_count", ackTotal - base, 3);
        checkOutput("burst_ovf_count", ovfTotal - ovfBase, 1);
        checkOutput("burst_order0", ackLog[base], 5'd1);
        checkOutput("burst_order1", ackLog[base + 1], 5'd2);
        checkOutput("burst_order2", ackLog[base + 2], 5'd4);
        checkOutput("burst_idle", busy, 0);
        doRead("rd_dropped", 10'h033, 5'd6, 1'b1, 8'h99, got);
        doRead("rd_third", 10'h032, 5'd6, 1'b1, 8'h33, got);

        // Wrong device, no hold, and the no-master ID must all be ignored.
        base = ackTotal;
        applyStimulus(1'b1, 5'd3, 10'h020, 5'd1, 1'b1, 8'hFF);
        tick();
        tick();
        checkOutput("nosel_dev_busy", busy, 0);
        applyStimulus(1'b0, 5'd1, 10'h020, 5'd1, 1'b1, 8'hFF);
        tick();
        tick();
        checkOutput("nosel_hold_busy", busy, 0);
        applyStimulus(1'b1, 5'd1, 10'h020, 5'h1F, 1'b1, 8'hFF);
        tick();
        tick();
        checkOutput("nosel_master_busy", busy, 0);
        holdFlag = 1'b0;
        repeat (3) tick();
        checkOutput("nosel_ack_count", ackTotal - base, 0);
        doRead("rd_nosel", 10'h020, 5'd2, 1'b1, 8'hA5, got);

        // Reset during the ACCESS cycle of a read.
        base = ackTotal;
        applyStimulus(1'b1, 5'd1, 10'h030, 5'd6, 1'b0, 8'h00);
        tick();
        checkOutput("rstmid_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        checkOutput("rstmid_ack", ack, 0);
        checkOutput("rstmid_busy", busy, 0);
        checkOutput("rstmid_rdata", rdata, 0);
        checkOutput("rstmid_master", respMaster, 5'h1F);
        holdFlag = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        repeat (4) tick();
        checkOutput("rstmid_no_ack", ackTotal - base, 0);
        doRead("rd_after_rst", 10'h031, 5'd7, 1'b1, 8'h22, got);

`ifdef XSIM_SLAVE_WPROT_EN
        doRead("wp_rd_before", 10'h004, 5'd2, 1'b0, 8'h00, oldVal);
        doWrite("wp_wr4", 10'h004, 5'd3, 8'h5A, 1'b1);
        doRead("wp_rd4", 10'h004, 5'd2, 1'b1, oldVal, got);
        doWrite("wp_wr16", 10'h010, 5'd3, 8'h66, 1'b0);
        doRead("wp_rd16", 10'h010, 5'd2, 1'b1, 8'h66, got);
`else
        oldVal = 8'h00;
        doWrite("nowp_wr4", 10'h004, 5'd3, 8'h5A, 1'b0);
        doRead("nowp_rd4", 10'h004, 5'd2, 1'b1, 8'h5A, got);
        doWrite("nowp_wr16", 10'h010, 5'd3, 8'h66, oldVal[0]);
        doRead("nowp_rd16", 10'h010, 5'd2, 1'b1, 8'h66, got);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
